semaphore_arbiter: RTL and testbench

Owns a bank of hardware semaphores shared by all cores of the multicore PLC. It accepts acquire and release requests from every core and arbitrates simultaneous acquires round-robin per semaphore. It holds the owner and lock state of each semaphore and produces the flattened per-core blocking vector consumed by the semaphore blocking multiplexer. It sits between the cores' semaphore access ports and that multiplexer.

---
 rtl/semaphore_pkg.sv | 16 +
 rtl/semaphore_rr_arbiter.sv | 41 ++++
 rtl/semaphore_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_semaphore_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/semaphore_pkg.sv
// Shared definitions for the hardware semaphore bank: operation encoding,
// semaphore index width and the core-id width helper.
package semaphore_pkg;

  localparam logic SEM_OP_ACQUIRE = 1'b1;
  localparam logic SEM_OP_RELEASE = 1'b0;

  // Every core addresses the bank with a fixed 8-bit semaphore index.
  localparam int unsigned SEM_ADDR_W = 8;

  // Width of a core id; a single-core system still carries a 1-bit id.
  function automatic int unsigned core_id_width(input int unsigned num_cores);
    return (num_cores > 1) ? int'($clog2(num_cores)) : 1;
  endfunction

endpackage

// File: rtl/semaphore_rr_arbiter.sv
// Combinational round-robin pick among the cores requesting one semaphore.
// The winner is the first requesting core strictly after ptr_i, wrapping.
module semaphore_rr_arbiter
  import semaphore_pkg::*;
#(
  parameter int unsigned NumberOfCores = 2,
  localparam int unsigned CoreIdW = core_id_width(NumberOfCores)
) (
  input  logic [NumberOfCores-1:0] req_i,
  input  logic [CoreIdW-1:0]       ptr_i,
  output logic [NumberOfCores-1:0] gnt_o,
  output logic                     valid_o
);

  logic [NumberOfCores-1:0] gnt_hi;
  logic [NumberOfCores-1:0] gnt_lo;
  logic                     found_hi;
  logic                     found_lo;

  // Lowest requester above the pointer, and lowest requester overall for wrap.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned j = 0; j < NumberOfCores; j++) begin
      if (req_i[j] && !found_hi && (j > 32'(ptr_i))) begin
        gnt_hi[j] = 1'b1;
        found_hi  = 1'b1;
      end
      if (req_i[j] && !found_lo) begin
        gnt_lo[j] = 1'b1;
        found_lo  = 1'b1;
      end
    end
  end

  assign gnt_o   = found_hi ? gnt_hi : gnt_lo;
  assign valid_o = found_lo;

endmodule

// File: rtl/semaphore_arbiter.sv
// Bank of hardware semaphores shared by all PLC cores. Takes per-core
// acquire/release requests, arbitrates acquires round-robin per semaphore,
// and drives the per-core blocking vector for the blocking multiplexer.
// Optional feature macro: SEMAPHORE_TIMEOUT_EN (forced release after
// HoldTimeout locked cycles, with a Timeout pulse to the evicted owner).
module semaphore_arbiter
  import semaphore_pkg::*;
#(
  parameter int unsigned NumberOfSemaphores = 4,
  parameter int unsigned NumberOfCores      = 2,
  parameter int unsigned HoldTimeout        = 1024
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NumberOfCores-1:0]                    SEMARB_Req_fromCPU,
  input  logic [NumberOfCores-1:0]                    SEMARB_Op_fromCPU,
  input  logic [SEM_ADDR_W*NumberOfCores-1:0]         SEMARB_Addr_fromCPU,
  output logic [NumberOfCores-1:0]                    SEMARB_Ack_toCPU,
  output logic [NumberOfCores-1:0]                    SEMARB_Error_toCPU,
  output logic [NumberOfSemaphores-1:0]               SEMARB_Locked_toDebug,
  output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMARB_Blocking_toMux
`ifdef SEMAPHORE_TIMEOUT_EN
  ,
  output logic [NumberOfCores-1:0]                    SEMARB_Timeout_toCPU
`endif
);

  localparam int unsigned NS      = NumberOfSemaphores;
  localparam int unsigned NC      = NumberOfCores;
  localparam int unsigned CoreIdW = core_id_width(NC);

  typedef logic [CoreIdW-1:0] core_id_t;

  // Reject parameter sets the bank cannot represent.
  if (NS < 1 || NS > 256 || NC < 1 || HoldTimeout < 1) begin : g_bad_cfg
    $error("semaphore_arbiter: unsupported parameter set");
  end

  logic     [NS-1:0]                 locked_q, locked_d;
  core_id_t [NS-1:0]                 owner_q, owner_d;
  core_id_t [NS-1:0]                 rr_q, rr_d;
  logic     [NC-1:0]                 ack_q, ack_d;
  logic     [NC-1:0]                 err_q, err_d;

  logic     [NC-1:0][SEM_ADDR_W-1:0] addr;
  logic     [NC-1:0]                 sample;
  logic     [NC-1:0]                 in_range;
  logic     [NC-1:0]                 is_acq;
  logic     [NC-1:0]                 rel_ok;
  logic     [NS-1:0]                 rel_hit;
  logic     [NS-1:0][NC-1:0]         acq_req;
  logic     [NS-1:0][NC-1:0]         gnt;
  logic     [NS-1:0]                 gnt_valid;

`ifdef SEMAPHORE_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(HoldTimeout + 1);
  logic [NS-1:0][HoldW-1:0] hold_q, hold_d;
  logic [NC-1:0]            timeout_q, timeout_d;
`endif

  assign addr   = SEMARB_Addr_fromCPU;
  // A request is never taken in its own ack cycle.
  assign sample = SEMARB_Req_fromCPU & ~ack_q;

  // Decode sampled requests into per-semaphore acquire candidates and owner releases.
  always_comb begin
    in_range = '0;
    is_acq   = '0;
    rel_ok   = '0;
    rel_hit  = '0;
    acq_req  = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      in_range[c] = (32'(addr[c]) < NS);
      is_acq[c]   = (SEMARB_Op_fromCPU[c] == SEM_OP_ACQUIRE);
      for (int unsigned s = 0; s < NS; s++) begin
        if (sample[c] && (32'(addr[c]) == s)) begin
          if (is_acq[c]) begin
            // Acquirers only compete for a semaphore that was free this cycle.
            acq_req[s][c] = !locked_q[s];
          end else if ((SEMARB_Op_fromCPU[c] == SEM_OP_RELEASE) && locked_q[s] &&
                       (owner_q[s] == CoreIdW'(c))) begin
            rel_ok[c]  = 1'b1;
            rel_hit[s] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_arb
    semaphore_rr_arbiter #(
      .NumberOfCores(NC)
    ) u_arb (
      .req_i  (acq_req[s]),
      .ptr_i  (rr_q[s]),
      .gnt_o  (gnt[s]),
      .valid_o(gnt_valid[s])
    );
  end

  // Next lock/owner/pointer state and per-core completion.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    ack_d    = '0;
    err_d    = '0;
`ifdef SEMAPHORE_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = '0;
`endif
    for (int unsigned s = 0; s < NS; s++) begin
      if (rel_hit[s]) begin
        locked_d[s] = 1'b0;
`ifdef SEMAPHORE_TIMEOUT_EN
        hold_d[s] = '0;
      end else if (locked_q[s]) begin
        if (32'(hold_q[s]) + 32'd1 == HoldTimeout) begin
          locked_d[s] = 1'b0;
          hold_d[s]   = '0;
          for (int unsigned c = 0; c < NC; c++) begin
            if (owner_q[s] == CoreIdW'(c)) timeout_d[c] = 1'b1;
          end
        end else begin
          hold_d[s] = hold_q[s] + HoldW'(1);
        end
`endif
      end else if (gnt_valid[s]) begin
        locked_d[s] = 1'b1;
`ifdef SEMAPHORE_TIMEOUT_EN
        hold_d[s] = '0;
`endif
        for (int unsigned c = 0; c < NC; c++) begin
          if (gnt[s][c]) begin
            owner_d[s] = CoreIdW'(c);
            rr_d[s]    = CoreIdW'(c);
          end
        end
      end
    end

    for (int unsigned c = 0; c < NC; c++) begin
      if (sample[c]) begin
        if (!in_range[c]) begin
          ack_d[c] = 1'b1;
          err_d[c] = 1'b1;
        end else if (!is_acq[c]) begin
          ack_d[c] = 1'b1;
          err_d[c] = !rel_ok[c];
        end else begin
          for (int unsigned s = 0; s < NS; s++) begin
            if (gnt[s][c]) ack_d[c] = 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset drops every lock and pending completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q  <= '0;
      owner_q   <= '0;
      rr_q      <= {NS{CoreIdW'(NC - 1)}};
      ack_q     <= '0;
      err_q     <= '0;
`ifdef SEMAPHORE_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= '0;
`endif
    end else begin
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
`ifdef SEMAPHORE_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Core c is blocked on s whenever s is held by some other core.
  always_comb begin
    SEMARB_Blocking_toMux = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned c = 0; c < NC; c++) begin
        SEMARB_Blocking_toMux[s*NC+c] = locked_q[s] && (owner_q[s] != CoreIdW'(c));
      end
    end
  end

  assign SEMARB_Ack_toCPU      = ack_q;
  assign SEMARB_Error_toCPU    = err_q;
  assign SEMARB_Locked_toDebug = locked_q;
`ifdef SEMAPHORE_TIMEOUT_EN
  assign SEMARB_Timeout_toCPU  = timeout_q;
`endif

endmodule

// File: tb/tb_semaphore_arbiter.sv
// Directed bench for semaphore_arbiter (4 semaphores, 2 cores, HoldTimeout 8).
// Builds with or without SEMAPHORE_TIMEOUT_EN.
module tb_semaphore_arbiter;
  import semaphore_pkg::*;

`ifdef SEMAPHORE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [1:0]      req;
  logic [1:0]      op;
  logic [1:0][7:0] addr_v;
  logic [1:0]      ack;
  logic [1:0]      err;
  logic [3:0]      locked;
  logic [7:0]      blk;
`ifdef SEMAPHORE_TIMEOUT_EN
  logic [1:0]      tmo;
`endif

  int n_checks = 0;
  int n_errors = 0;

  semaphore_arbiter #(
    .NumberOfSemaphores(4),
    .NumberOfCores     (2),
    .HoldTimeout       (8)
  ) dut (
    .clk                  (clk),
    .reset                (rst),
    .SEMARB_Req_fromCPU   (req),
    .SEMARB_Op_fromCPU    (op),
    .SEMARB_Addr_fromCPU  (addr_v),
    .SEMARB_Ack_toCPU     (ack),
    .SEMARB_Error_toCPU   (err),
    .SEMARB_Locked_toDebug(locked),
    .SEMARB_Blocking_toMux(blk)
`ifdef SEMAPHORE_TIMEOUT_EN
    ,
    .SEMARB_Timeout_toCPU (tmo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] a, input logic [1:0] e,
                            input logic [3:0] l, input logic [7:0] b);
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".blocking"}, 32'(blk), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit c, input logic o, input logic [7:0] a);
    req[c]    = 1'b1;
    op[c]     = o;
    addr_v[c] = a;
  endtask

  // Drop all requests and confirm the ack pulse lasted one cycle.
  task automatic idle(input string tag);
    req = '0;
    step();
    chk({tag, ".ack_end"}, 32'(ack), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    op     = '0;
    addr_v = '0;
    step();
    step();
    expect_out("reset", 2'b00, 2'b00, 4'b0000, 8'h00);
`ifdef SEMAPHORE_TIMEOUT_EN
    chk("reset.timeout", 32'(tmo), 32'd0);
`endif
    rst = 1'b0;

    // Uncontended acquire: blocking bit 3 set (s1 owned by core 0 blocks core 1).
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd1);
    step();
    expect_out("acq_s1", 2'b01, 2'b00, 4'b0010, 8'h08);
    idle("acq_s1");
    set_req(1'b0, SEM_OP_RELEASE, 8'd1);
    step();
    expect_out("rel_s1", 2'b01, 2'b00, 4'b0000, 8'h00);
    idle("rel_s1");

    // Contention with reset pointer: core 0 wins, core 1 waits.
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd2);
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd2);
    step();
    expect_out("contend1", 2'b01, 2'b00, 4'b0100, 8'h20);
    req[0] = 1'b0;
    step();
    expect_out("contend1_wait", 2'b00, 2'b00, 4'b0100, 8'h20);
    // Owner release while core 1 still acquires: release first, handover next cycle.
    set_req(1'b0, SEM_OP_RELEASE, 8'd2);
    step();
    expect_out("rel_race", 2'b01, 2'b00, 4'b0000, 8'h00);
    req[0] = 1'b0;
    step();
    expect_out("handover", 2'b10, 2'b00, 4'b0100, 8'h10);
    idle("handover");
    set_req(1'b1, SEM_OP_RELEASE, 8'd2);
    step();
    expect_out("rel_c1", 2'b10, 2'b00, 4'b0000, 8'h00);
    idle("rel_c1");

    // Pointer now at core 1, so core 0 wins the next contention.
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd2);
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd2);
    step();
    expect_out("contend2", 2'b01, 2'b00, 4'b0100, 8'h20);
    req[0] = 1'b0;
    step();
    set_req(1'b0, SEM_OP_RELEASE, 8'd2);
    step();
    expect_out("rel_race2", 2'b01, 2'b00, 4'b0000, 8'h00);
    req[0] = 1'b0;
    step();
    expect_out("handover2", 2'b10, 2'b00, 4'b0100, 8'h10);
    idle("handover2");
    set_req(1'b1, SEM_OP_RELEASE, 8'd2);
    step();
    expect_out("rel_c1b", 2'b10, 2'b00, 4'b0000, 8'h00);
    idle("rel_c1b");

    // Error paths: out-of-range index, release of a free semaphore.
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd4);
    step();
    expect_out("acq_oor", 2'b10, 2'b10, 4'b0000, 8'h00);
    idle("acq_oor");
    set_req(1'b0, SEM_OP_RELEASE, 8'd3);
    step();
    expect_out("rel_free", 2'b01, 2'b01, 4'b0000, 8'h00);
    idle("rel_free");
    set_req(1'b0, SEM_OP_RELEASE, 8'd200);
    set_req(1'b1, SEM_OP_RELEASE, 8'd1);
    step();
    expect_out("dual_err", 2'b11, 2'b11, 4'b0000, 8'h00);
    idle("dual_err");

    // Release by a non-owner leaves the lock with core 0.
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd0);
    step();
    expect_out("acq_s0", 2'b01, 2'b00, 4'b0001, 8'h02);
    idle("acq_s0");
    set_req(1'b1, SEM_OP_RELEASE, 8'd0);
    step();
    expect_out("rel_nonowner", 2'b10, 2'b10, 4'b0001, 8'h02);
    idle("rel_nonowner");
    set_req(1'b0, SEM_OP_RELEASE, 8'd0);
    step();
    expect_out("rel_s0", 2'b01, 2'b00, 4'b0000, 8'h00);
    idle("rel_s0");

    // Owner re-acquiring its own lock waits; then reset mid-cycle.
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd3);
    step();
    expect_out("acq_s3", 2'b10, 2'b00, 4'b1000, 8'h40);
    idle("acq_s3");
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd3);
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd2);
    step();
    expect_out("recursive", 2'b01, 2'b00, 4'b1100, 8'h60);
    req[0] = 1'b0;
    step();
    expect_out("recursive_wait", 2'b00, 2'b00, 4'b1100, 8'h60);
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd1);
    step();
    expect_out("pre_rst", 2'b01, 2'b00, 4'b1110, 8'h68);
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 2'b00, 2'b00, 4'b0000, 8'h00);
    req = '0;
    step();
    rst = 1'b0;
    set_req(1'b0, SEM_OP_ACQUIRE, 8'd3);
    step();
    expect_out("reacq", 2'b01, 2'b00, 4'b1000, 8'h80);
    idle("reacq");
    set_req(1'b0, SEM_OP_RELEASE, 8'd3);
    step();
    expect_out("rel_s3", 2'b01, 2'b00, 4'b0000, 8'h00);
    idle("rel_s3");

    // Long hold: forced release after 8 locked cycles only with the timeout feature.
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd0);
    step();
    expect_out("to_acq", 2'b10, 2'b00, 4'b0001, 8'h01);
    req = '0;
    for (int i = 1; i <= 7; i++) step();
    expect_out("to_hold7", 2'b00, 2'b00, 4'b0001, 8'h01);
    step();
    expect_out("to_hold8", 2'b00, 2'b00, TO_EN ? 4'b0000 : 4'b0001, TO_EN ? 8'h00 : 8'h01);
`ifdef SEMAPHORE_TIMEOUT_EN
    chk("to_fire", 32'(tmo), 32'd2);
    step();
    chk("to_pulse_end", 32'(tmo), 32'd0);
`else
    step();
`endif
    set_req(1'b1, SEM_OP_RELEASE, 8'd0);
    step();
    expect_out("to_late_rel", 2'b10, TO_EN ? 2'b10 : 2'b00, 4'b0000, 8'h00);
    idle("to_late_rel");

    // Owner release on the 8th locked cycle beats the forced release.
    set_req(1'b1, SEM_OP_ACQUIRE, 8'd0);
    step();
    expect_out("race_acq", 2'b10, 2'b00, 4'b0001, 8'h01);
    req = '0;
    for (int i = 1; i <= 7; i++) step();
    set_req(1'b1, SEM_OP_RELEASE, 8'd0);
    step();
    expect_out("race_rel", 2'b10, 2'b00, 4'b0000, 8'h00);
`ifdef SEMAPHORE_TIMEOUT_EN
    chk("race_no_timeout", 32'(tmo), 32'd0);
`endif
    req = '0;
    step();
    chk("race_ack_end", 32'(ack), 32'd0);
`ifdef SEMAPHORE_TIMEOUT_EN
    chk("race_no_timeout2", 32'(tmo), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
